// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RISC-V pipeline.
//
// Non-memory instructions pass straight through combinationally. Loads and
// stores are serialised into little-endian byte transfers on the byte-wide
// RAM/UART arbiter port, and the pipeline is held via stallreq_mem until the
// access completes. A completed load is presented for exactly one cycle.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned halfword and
// word accesses in IDLE (no RAM traffic, exc_misaligned pulses for one cycle).
// Without it, misaligned accesses are performed byte-serially and
// exc_misaligned is tied to 0.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ex_wd/ex_wreg     destination register / write enable from ex/mem
//   ex_wdata          ALU result for non-memory ops
//   ex_memop          0=none, 1=load, 2=store, 3=reserved (none)
//   ex_funct3         RISC-V funct3 of the load/store
//   ex_maddr          effective byte address
//   ex_sdata          store data (rs2)
//   mem_wd/mem_wreg/mem_wdata  write-back target, enable, data to mem_wb
//   stallreq_mem      stall request to the pipeline controller
//   ram_req/ram_we/ram_addr/ram_wdata  byte transfer request
//   ram_rdata/ram_done                 byte transfer response
//   exc_misaligned    misaligned-access flag
module mem_stage #(
    parameter int unsigned RAM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            ex_wd,
    input  logic                  ex_wreg,
    input  logic [31:0]           ex_wdata,
    input  logic [1:0]            ex_memop,
    input  logic [2:0]            ex_funct3,
    input  logic [31:0]           ex_maddr,
    input  logic [31:0]           ex_sdata,
    output logic [4:0]            mem_wd,
    output logic                  mem_wreg,
    output logic [31:0]           mem_wdata,
    output logic                  stallreq_mem,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    input  logic                  ram_done,
    output logic                  exc_misaligned
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] data_buf_q, data_buf_d;

    logic        is_load, is_store, is_mem, bad_enc, trap, last_byte;
    logic [1:0]  last_idx;
    logic [31:0] byte_addr, sdata_sh, load_ext;

    // Only encodings the stage can actually perform count as memory ops;
    // anything else with memop=load/store becomes a non-writing pass-through.
    always_comb begin
        is_load  = (ex_memop == 2'd1) &&
                   (ex_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        is_store = (ex_memop == 2'd2) && (ex_funct3 inside {3'd0, 3'd1, 3'd2});
        is_mem   = is_load || is_store;
        bad_enc  = ((ex_memop == 2'd1) || (ex_memop == 2'd2)) && !is_mem;
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    always_comb begin
        misaligned = ((ex_funct3[1:0] == 2'd1) && ex_maddr[0]) ||
                     ((ex_funct3[1:0] == 2'd2) && (ex_maddr[1:0] != 2'd0));
        trap       = is_mem && misaligned;
    end
`else
    assign trap = 1'b0;
`endif

    // funct3[1:0] = 0/1/2 -> 1/2/4 bytes, i.e. last byte index 0/1/3
    assign last_idx  = (ex_funct3[1:0] == 2'd2) ? 2'd3 : ex_funct3[1:0];
    assign last_byte = (idx_q == last_idx);
    assign byte_addr = ex_maddr + {30'd0, idx_q};
    assign sdata_sh  = ex_sdata >> {idx_q, 3'b000};

    always_comb begin
        case (ex_funct3)
            3'd0:    load_ext = {{24{data_buf_q[7]}}, data_buf_q[7:0]};
            3'd1:    load_ext = {{16{data_buf_q[15]}}, data_buf_q[15:0]};
            3'd4:    load_ext = {24'd0, data_buf_q[7:0]};
            3'd5:    load_ext = {16'd0, data_buf_q[15:0]};
            default: load_ext = data_buf_q;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        data_buf_d     = data_buf_q;
        mem_wd         = ex_wd;
        mem_wreg       = 1'b0;
        mem_wdata      = '0;
        stallreq_mem   = 1'b0;
        ram_req        = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        exc_misaligned = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trap) begin
                    exc_misaligned = 1'b1;
                end else if (is_mem) begin
                    stallreq_mem = 1'b1;
                    state_d      = S_ACCESS;
                    idx_d        = '0;
                    data_buf_d   = '0;
                end else begin
                    mem_wreg  = ex_wreg && !bad_enc;
                    mem_wdata = ex_wdata;
                end
            end
            S_ACCESS: begin
                ram_req      = 1'b1;
                ram_we       = is_store;
                ram_addr     = byte_addr[RAM_ADDR_W-1:0];
                ram_wdata    = sdata_sh[7:0];
                stallreq_mem = 1'b1;
                if (ram_done) begin
                    if (is_load) begin
                        data_buf_d[8*idx_q +: 8] = ram_rdata;
                    end
                    if (last_byte) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (is_load) begin
                    mem_wreg  = ex_wreg;
                    mem_wdata = load_ext;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are quiet for as long as reset is held, so an access cut
        // off by reset drops ram_req at once and leaks no partial result.
        if (!rst) begin
            mem_wd         = '0;
            mem_wreg       = 1'b0;
            mem_wdata      = '0;
            stallreq_mem   = 1'b0;
            ram_req        = 1'b0;
            ram_we         = 1'b0;
            ram_addr       = '0;
            ram_wdata      = '0;
            exc_misaligned = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            data_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_buf_q <= data_buf_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ex_wd;
    logic          ex_wreg;
    logic [31:0]   ex_wdata;
    logic [1:0]    ex_memop;
    logic [2:0]    ex_funct3;
    logic [31:0]   ex_maddr;
    logic [31:0]   ex_sdata;
    logic [4:0]    mem_wd;
    logic          mem_wreg;
    logic [31:0]   mem_wdata;
    logic          stallreq_mem;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = 8'h00;
    logic          ram_done = 1'b0;
    logic          exc_misaligned;

    mem_stage #(.RAM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_memop(ex_memop), .ex_funct3(ex_funct3),
        .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stallreq_mem(stallreq_mem),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_done(ram_done),
        .exc_misaligned(exc_misaligned)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- RAM responder / transaction log ----------------
    logic [7:0]  mem [logic [31:0]];
    int          resp_delay = 0;
    int          cnt = 0;
    logic        force_done = 1'b0;
    logic [31:0] txa_q[$];
    logic        txw_q[$];
    logic [7:0]  txd_q[$];

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Each byte request is answered resp_delay cycles after it first appears.
    always @(negedge clk) begin
        if (ram_req) begin
            if (cnt == resp_delay) begin
                ram_done  <= 1'b1;
                ram_rdata <= mem_rd(ram_addr);
                txa_q.push_back(ram_addr);
                txw_q.push_back(ram_we);
                txd_q.push_back(ram_wdata);
                cnt <= 0;
            end else begin
                ram_done  <= 1'b0;
                ram_rdata <= 8'h00;
                cnt <= cnt + 1;
            end
        end else begin
            ram_done  <= force_done;
            ram_rdata <= 8'h5C;
            cnt <= 0;
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model driven operation ----------------
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg,
                         input int dly, input string nm);
        int          n, cycles, exp_stall;
        logic        ld, misal, trap, wreg_seen;
        logic [31:0] v, a;
        logic [7:0]  b;
        ld    = (op == 2'd1);
        n     = (f3[1:0] == 2'd2) ? 4 : int'(f3[1:0]) + 1;
        misal = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
`ifdef MEM_ALIGN_CHECK_EN
        trap = misal;
`else
        trap = 1'b0;
`endif
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | (32'(mem_rd(a)) << (8 * i));
        end
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        exp_stall = trap ? 0 : 1 + n * (dly + 1);

        txa_q.delete(); txw_q.delete(); txd_q.delete();
        resp_delay = dly;
        ex_memop = op; ex_funct3 = f3; ex_maddr = addr; ex_sdata = sdata;
        ex_wd = wd; ex_wreg = wreg; ex_wdata = 32'hCAFE_0000 ^ addr;

        cycles = 0;
        wreg_seen = 1'b0;
        sample();
        while (stallreq_mem && cycles < 200) begin
            cycles++;
            if (mem_wreg) wreg_seen = 1'b1;
            sample();
        end
        chk({nm, " stall cycles"}, 32'(cycles), 32'(exp_stall));
        chk({nm, " wreg while stalled"}, {31'd0, wreg_seen}, 32'd0);
        chk({nm, " ram_req at result"}, {31'd0, ram_req}, 32'd0);
        chk({nm, " exc"}, {31'd0, exc_misaligned}, {31'd0, trap});
        chk({nm, " wd"}, {27'd0, mem_wd}, {27'd0, wd});
        chk({nm, " wreg"}, {31'd0, mem_wreg}, {31'd0, ld && !trap && wreg});
        chk({nm, " wdata"}, mem_wdata, (ld && !trap) ? v : 32'd0);
        chk({nm, " byte count"}, 32'(txa_q.size()), trap ? 32'd0 : 32'(n));
        if (!trap) begin
            for (int i = 0; i < n && i < txa_q.size(); i++) begin
                chk($sformatf("%s addr%0d", nm, i), txa_q[i], addr + 32'(i));
                chk($sformatf("%s we%0d", nm, i), {31'd0, txw_q[i]}, {31'd0, !ld});
                if (!ld) begin
                    v = sdata >> (8 * i);
                    b = v[7:0];
                    chk($sformatf("%s wbyte%0d", nm, i), {24'd0, txd_q[i]}, {24'd0, b});
                end
            end
        end
        next_cycle();
    endtask

    // ---------------- pass-through vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        exp_wreg;
    } pt_vec_t;

    pt_vec_t vecs[8];

    initial begin
        logic [1:0]  r_op;
        logic [2:0]  r_f3;
        logic [2:0]  ld_f3 [5];

        vecs[0] = '{2'd0, 3'd0, 5'd5,  1'b1, 32'h0000_1234, 1'b1};
        vecs[1] = '{2'd0, 3'd2, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{2'd1, 3'd3, 5'd1,  1'b1, 32'h0000_AAAA, 1'b0};
        vecs[3] = '{2'd1, 3'd6, 5'd2,  1'b1, 32'h1357_9BDF, 1'b0};
        vecs[4] = '{2'd1, 3'd7, 5'd3,  1'b1, 32'h8000_0001, 1'b0};
        vecs[5] = '{2'd2, 3'd4, 5'd4,  1'b1, 32'h0F0F_0F0F, 1'b0};
        vecs[6] = '{2'd2, 3'd3, 5'd9,  1'b1, 32'h7777_0000, 1'b0};
        vecs[7] = '{2'd0, 3'd5, 5'd17, 1'b1, 32'hA5A5_5A5A, 1'b1};
        ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

        // Reset holds every output low, even with a valid op presented.
        rst = 1'b0;
        ex_memop = 2'd0; ex_funct3 = 3'd0; ex_maddr = 32'h100; ex_sdata = 32'h0;
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        #12;
        chk("reset wd",    {27'd0, mem_wd}, 32'd0);
        chk("reset wreg",  {31'd0, mem_wreg}, 32'd0);
        chk("reset wdata", mem_wdata, 32'd0);
        ex_memop = 2'd1; ex_funct3 = 3'd2;
        #1;
        chk("reset stall", {31'd0, stallreq_mem}, 32'd0);
        chk("reset req",   {31'd0, ram_req}, 32'd0);
        ex_memop = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        foreach (vecs[k]) begin
            ex_memop = vecs[k].op; ex_funct3 = vecs[k].f3; ex_wd = vecs[k].wd;
            ex_wreg = vecs[k].wreg; ex_wdata = vecs[k].wdata; ex_maddr = 32'h40;
            sample();
            chk($sformatf("pt%0d wd", k),    {27'd0, mem_wd}, {27'd0, vecs[k].wd});
            chk($sformatf("pt%0d wreg", k),  {31'd0, mem_wreg}, {31'd0, vecs[k].exp_wreg});
            chk($sformatf("pt%0d wdata", k), mem_wdata, vecs[k].wdata);
            chk($sformatf("pt%0d stall", k), {31'd0, stallreq_mem}, 32'd0);
            chk($sformatf("pt%0d req", k),   {31'd0, ram_req}, 32'd0);
            next_cycle();
        end

        // Directed corner cases
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22;
        mem[32'h102] = 8'h33; mem[32'h103] = 8'h84;
        mem[32'h7]   = 8'h80;
        do_op(2'd1, 3'd2, 32'h100, 32'h0, 5'd7, 1'b1, 1, "lw100");
        do_op(2'd1, 3'd0, 32'h7, 32'h0, 5'd8, 1'b1, 0, "lb7");
        do_op(2'd1, 3'd4, 32'h7, 32'h0, 5'd9, 1'b1, 2, "lbu7");
        do_op(2'd2, 3'd1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd3, 1'b1, 0, "sh_wrap");
        do_op(2'd1, 3'd2, 32'h102, 32'h0, 5'd10, 1'b1, 0, "lw102");
        do_op(2'd2, 3'd0, 32'h40, 32'h0000_005A, 5'd11, 1'b1, 0, "sb_after");
        do_op(2'd1, 3'd1, 32'h101, 32'h0, 5'd12, 1'b1, 1, "lh101");

        // A ram_done pulse with no request outstanding must be ignored.
        force_done = 1'b1;
        ex_memop = 2'd0; ex_wd = 5'd6; ex_wreg = 1'b1; ex_wdata = 32'h55;
        sample();
        next_cycle();
        force_done = 1'b0;
        sample();
        chk("stray done stall", {31'd0, stallreq_mem}, 32'd0);
        chk("stray done req",   {31'd0, ram_req}, 32'd0);
        next_cycle();
        do_op(2'd1, 3'd2, 32'h100, 32'h0, 5'd13, 1'b1, 0, "lw_after_stray");

        // Reset after two bytes of a word load aborts it cleanly.
        resp_delay = 0;
        txa_q.delete(); txw_q.delete(); txd_q.delete();
        ex_memop = 2'd1; ex_funct3 = 3'd2; ex_maddr = 32'h200; ex_wd = 5'd14; ex_wreg = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (txa_q.size() >= 2) break;
        end
        chk("abort bytes before reset", 32'(txa_q.size()), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("abort req",   {31'd0, ram_req}, 32'd0);
        chk("abort stall", {31'd0, stallreq_mem}, 32'd0);
        chk("abort wreg",  {31'd0, mem_wreg}, 32'd0);
        next_cycle();
        ex_memop = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        do_op(2'd1, 3'd2, 32'h200, 32'h0, 5'd15, 1'b1, 0, "lw_after_reset");

        // Randomised loads/stores against the reference model
        for (int k = 0; k < 40; k++) begin
            r_op = 2'($urandom_range(1, 2));
            if (r_op == 2'd1) r_f3 = ld_f3[$urandom_range(0, 4)];
            else              r_f3 = 3'($urandom_range(0, 2));
            do_op(r_op, r_f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
